// File: rtl/clock_set_ctrl.sv
// Time-of-day controller: 1 Hz advance prescaler, two-button hour/minute
// set-mode FSM, and a one-cycle parallel load into the counter on exit.
//
// Button handshake: btn_mode/btn_inc are clk-synchronous levels; a press is
// the single cycle where the level is high and was low the cycle before, so
// a held button counts once. load is a one-cycle strobe and load_hours /
// load_mins are qualified by it (zero whenever load is low).
module clock_set_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_mins,
    output logic       tick,
    output logic       load,
    output logic [4:0] load_hours,
    output logic [5:0] load_mins,
    output logic [5:0] load_sec,
    output logic [1:0] set_mode,
    output logic [4:0] disp_hours,
    output logic [5:0] disp_mins,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2 - 1);

    state_t           state;
    state_t           state_nxt;
    logic             btn_mode_q;
    logic             btn_inc_q;
    logic             mode_press;
    logic             inc_press;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       hr_edit;
    logic [5:0]       min_edit;
    logic             state_change;
    logic             exit_set;

    assign mode_press   = btn_mode & ~btn_mode_q;
    assign inc_press    = btn_inc & ~btn_inc_q;
    assign state_change = (state_nxt != state);
    assign exit_set     = (state == SET_MIN) && mode_press;

    // State register; the state itself is visible on set_mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next state: every mode press steps RUN -> SET_HR -> SET_MIN -> RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mode_press) state_nxt = SET_HR;
            SET_HR:  if (mode_press) state_nxt = SET_MIN;
            SET_MIN: if (mode_press) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Button history for rising-edge press detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
        end else begin
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
        end
    end

    // Prescaler: wraps at TICK_DIV-1, restarts on every state change so the
    // first tick after a load lands exactly TICK_DIV cycles after the press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt <= '0;
        else if (state_change)    cnt <= '0;
        else if (cnt == CNT_LAST) cnt <= '0;
        else                      cnt <= cnt + 1'b1;
    end

    // Edit registers: snapshot on entry, increment with wrap; mode beats inc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_edit  <= '0;
            min_edit <= '0;
        end else if (state == RUN && mode_press) begin
            hr_edit  <= cur_hours;
            min_edit <= cur_mins;
        end else if (state == SET_HR && inc_press && !mode_press) begin
            hr_edit  <= (hr_edit == 5'd23) ? 5'd0 : hr_edit + 5'd1;
        end else if (state == SET_MIN && inc_press && !mode_press) begin
            min_edit <= (min_edit == 6'd59) ? 6'd0 : min_edit + 6'd1;
        end
    end

    // Blink: half-period toggle in SET states, restarted low on each entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                blink <= 1'b0;
        else if (state_change || state == RUN)  blink <= 1'b0;
        else if (cnt == CNT_HALF || cnt == CNT_LAST) blink <= ~blink;
    end

    // Registered load strobe, issued the cycle after the exiting mode press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load       <= 1'b0;
            load_hours <= '0;
            load_mins  <= '0;
        end else begin
            load       <= exit_set;
            load_hours <= exit_set ? hr_edit : 5'd0;
            load_mins  <= exit_set ? min_edit : 6'd0;
        end
    end

    assign load_sec   = 6'd0;
    assign tick       = (state == RUN) && (cnt == CNT_LAST) && !load;
    assign set_mode   = state;
    assign disp_hours = (state == RUN) ? cur_hours : hr_edit;
    assign disp_mins  = (state == RUN) ? cur_mins : min_edit;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with TICK_DIV=4: directed scenarios followed by
// random button/counter activity, checked against a phase-based model.
module tb_clock_set_ctrl;

  localparam int TD = 4;
  localparam int W  = 33;
  localparam int LW = 11;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hours;
  logic [5:0] cur_mins;
  logic       tick;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_mins;
  logic [5:0] load_sec;
  logic [1:0] set_mode;
  logic [4:0] disp_hours;
  logic [5:0] disp_mins;
  logic       blink;

  clock_set_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_mins(cur_mins), .tick(tick), .load(load),
    .load_hours(load_hours), .load_mins(load_mins), .load_sec(load_sec),
    .set_mode(set_mode), .disp_hours(disp_hours), .disp_mins(disp_mins),
    .blink(blink)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [LW-1:0] load_q[$];

  // reference model: mode, cycles since entering the mode, edit values
  int m_mode, m_phase, m_hr, m_min, m_lh, m_lm;
  bit m_mprev, m_iprev, m_load;

  function automatic void model_reset();
    m_mode = 0; m_phase = 0; m_hr = 0; m_min = 0; m_lh = 0; m_lm = 0;
    m_mprev = 0; m_iprev = 0; m_load = 0;
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic       t, b;
    logic [4:0] dh, lh;
    logic [5:0] dm, lm;
    t  = (m_mode == 0) && ((m_phase % TD) == TD - 1);
    b  = (m_mode != 0) && (((m_phase / (TD / 2)) % 2) == 1);
    dh = (m_mode == 0) ? cur_hours : 5'(m_hr);
    dm = (m_mode == 0) ? cur_mins  : 6'(m_min);
    lh = m_load ? 5'(m_lh) : 5'd0;
    lm = m_load ? 6'(m_lm) : 6'd0;
    return {t, m_load, lh, lm, 6'd0, 2'(m_mode), dh, dm, b};
  endfunction

  function automatic void model_advance(bit mp, bit ip);
    bit mpress, ipress, new_load;
    int old_mode;
    mpress = mp && !m_mprev;
    ipress = ip && !m_iprev;
    m_mprev = mp;
    m_iprev = ip;
    old_mode = m_mode;
    new_load = (m_mode == 2) && mpress;
    if (new_load) begin
      m_lh = m_hr;
      m_lm = m_min;
      load_q.push_back({5'(m_hr), 6'(m_min)});
    end
    case (m_mode)
      0: if (mpress) begin m_hr = cur_hours; m_min = cur_mins; m_mode = 1; end
      1: if (mpress) m_mode = 2; else if (ipress) m_hr = (m_hr + 1) % 24;
      default: if (mpress) m_mode = 0; else if (ipress) m_min = (m_min + 1) % 60;
    endcase
    m_load = new_load;
    m_phase = (m_mode != old_mode) ? 0 : m_phase + 1;
  endfunction

  // driver tasks (called at a negedge)
  task automatic step(input bit mp, input bit ip);
    btn_mode = mp;
    btn_inc  = ip;
    exp_q.push_back(model_outputs());
    model_advance(mp, ip);
    @(negedge clk);
  endtask

  task automatic press(input bit mp, input bit ip);
    step(mp, ip);
    step(1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_tick", int'(tick), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_load_hours", int'(load_hours), 0);
    chk("rst_load_mins", int'(load_mins), 0);
    chk("rst_load_sec", int'(load_sec), 0);
    chk("rst_set_mode", int'(set_mode), 0);
    chk("rst_blink", int'(blink), 0);
    chk("rst_disp_hours", int'(disp_hours), int'(cur_hours));
    chk("rst_disp_mins", int'(disp_mins), int'(cur_mins));
  endtask

  // scoreboard monitor
  logic [W-1:0]  act_vec;
  assign act_vec = {tick, load, load_hours, load_mins, load_sec, set_mode,
                    disp_hours, disp_mins, blink};

  always @(negedge clk) begin
    logic [W-1:0]  e;
    logic [LW-1:0] le;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_vec !== e) begin
        errors++;
        $display("FAIL outputs t=%0t actual=%h required=%h", $time, act_vec, e);
      end
    end
    if (load === 1'b1) begin
      checks++;
      if (load_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected t=%0t actual=%0d:%0d required=no load",
                 $time, load_hours, load_mins);
      end else begin
        le = load_q.pop_front();
        if ({load_hours, load_mins} !== le) begin
          errors++;
          $display("FAIL load_value t=%0t actual=%0d:%0d required=%0d:%0d",
                   $time, load_hours, load_mins, le[10:6], le[5:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hours = 5'd0; cur_mins = 6'd0;
    #1 rst = 1'b1;
    #2 check_reset_state();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // idle run: ticks every TD cycles, no load
    repeat (12) step(1'b0, 1'b0);

    // 10:20 -> hours +15 (wraps to 1), minutes +40 (wraps to 0), load 01:00
    cur_hours = 5'd10; cur_mins = 6'd20;
    press(1'b1, 1'b0);
    repeat (15) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (40) press(1'b0, 1'b1);
    cur_hours = 5'd17; cur_mins = 6'd42;
    press(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);

    // mode+inc together in SET_HR: mode wins
    cur_hours = 5'd4; cur_mins = 6'd10;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);

    // held inc in SET_MIN counts once; blink runs, tick stays low
    cur_hours = 5'd23; cur_mins = 6'd59;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);

    // reset while in SET_MIN: immediate RUN, no load afterwards
    press(1'b0, 1'b1);
    #3 rst = 1'b1;
    #1 check_reset_state();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) step(1'b0, 1'b0);

    // random activity
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) begin
        cur_hours = 5'($urandom_range(0, 23));
        cur_mins  = 6'($urandom_range(0, 59));
      end
      step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0));
    end
    repeat (2 * TD) step(1'b0, 1'b0);

    @(negedge clk);
    #2;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("load_q_drained", load_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
